vga_frame_reader: RTL and testbench
===================================

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 16, pixel word width in RGB565.
- ROW_BITS, 9, read row address width.
- COL_BITS, 10, read column address width.
- H_VISIBLE/H_FRONT/H_SYNC/H_BACK, 640/16/96/48, horizontal timing in pixel ticks.
- V_VISIBLE/V_FRONT/V_SYNC/V_BACK, 480/10/2/33, vertical timing in lines.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning), one per line:
- Clock, in, 1, sole clock; all state updates on rising edge.
- Reset, in, 1, synchronous, active-high.
- iPixelEnable, in, 1, pixel tick strobe; timing advances only when high.
- iDataIn, in, DATA_WIDTH, framebuffer read data, valid one Clock after the address.
- oReadRow, out, ROW_BITS, framebuffer read row.
- oReadCol, out, COL_BITS, framebuffer read column.
- oRed, out, 5, pixel red.
- oGreen, out, 6, pixel green.
- oBlue, out, 5, pixel blue.
- oHSync, out, 1, horizontal sync, active-low.
- oVSync, out, 1, vertical sync, active-low.
- oBlank, out, 1, high outside the visible area.
- oFrameStart, out, 1, one-Clock pulse at frame origin.

Function
REQ-004 Horizontal counter hcnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_*, 800), incrementing on each Clock with iPixelEnable=1, wrapping to 0.
REQ-005 Vertical counter vcnt SHALL count 0..V_TOTAL-1 (525); it increments only on the tick where hcnt wraps, and wraps to 0 after V_TOTAL-1.
REQ-006 Both counters SHALL hold their value on any Clock with iPixelEnable=0.
REQ-007 Visible region SHALL be hcnt<H_VISIBLE and vcnt<V_VISIBLE.
REQ-008 oReadCol/oReadRow SHALL equal hcnt/vcnt, truncated to COL_BITS/ROW_BITS, in the visible region, and 0 otherwise.
REQ-009 Raw hsync SHALL be low for hcnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656,751]; otherwise high.
REQ-010 Raw vsync SHALL be low for vcnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490,491]; otherwise high.
REQ-011 Raw blank, hsync and vsync SHALL pass through a two-stage pipeline that advances only on pixel ticks, so outputs lag the counters by exactly 2 pixel ticks.
REQ-012 On the second pipeline stage's tick, the block SHALL capture iDataIn.
- If delayed blank=0: oRed=iDataIn[15:11], oGreen=iDataIn[10:5], oBlue=iDataIn[4:0].
- If delayed blank=1: all colour outputs SHALL be 0.
REQ-013 oHSync, oVSync, oBlank and colour outputs SHALL be registered and change only on pixel ticks.
REQ-014 oFrameStart SHALL pulse high for exactly one Clock when delayed (hcnt,vcnt)=(0,0) enters the output stage; it is never high two consecutive Clocks.
REQ-015 With iPixelEnable permanently high, the pixel at address (c,r) SHALL appear on the colour outputs exactly 2 Clocks after the address is driven.
REQ-016 With gapped iPixelEnable, the address SHALL remain stable between ticks; repeated reads of the same address are permitted.

Reset
REQ-017 While Reset=1 on a rising edge:
- hcnt, vcnt and all pipeline stages SHALL clear.
- Outputs SHALL become: oHSync=1, oVSync=1, oBlank=1, colours=0, oFrameStart=0, oReadRow=0, oReadCol=0.
REQ-018 Reset SHALL take priority over iPixelEnable.
REQ-019 After deassertion, the first tick SHALL restart at hcnt=0, vcnt=0, including when reset is asserted mid-line or mid-frame.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- Line timing: iPixelEnable=1 continuously. oHSync low for 96 Clocks; falling edge at 658 Clocks after the line origin; line period 800 Clocks.
- Frame timing: oVSync low for 2 lines (1600 Clocks); frame period 420000 Clocks; oFrameStart pulses once per 420000 Clocks.
- Data path: RAM model returns 16'hF800 at (0,0) and 16'h07E0 at (1,0). Output (31,0,0) then (0,63,0) on Clocks 2 and 3 after the origin.
- Blanking: RAM model returns 16'hFFFF everywhere. Colours are 0 whenever oBlank=1, e.g. at hcnt 642..801 delayed; oReadCol=0 while hcnt≥640.
- Gapped enable: iPixelEnable high every 4th Clock. Counters and outputs hold between ticks; line period is 3200 Clocks.
- Reset mid-frame: Reset pulsed at vcnt=200, hcnt=300. Next Clock shows the REQ-017 values; after release, oFrameStart fires 2 ticks later.

Source files
------------

// File: rtl/vga_frame_reader.sv
// VGA 640x480 timing generator and framebuffer reader.
// Drives a one-cycle-latency read port and outputs RGB565 pixels with sync/blank, two ticks behind.
module vga_frame_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ROW_BITS   = 9,
    parameter int unsigned COL_BITS   = 10,
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iPixelEnable,
    input  logic [DATA_WIDTH-1:0] iDataIn,
    output logic [ROW_BITS-1:0]   oReadRow,
    output logic [COL_BITS-1:0]   oReadCol,
    output logic [4:0]            oRed,
    output logic [5:0]            oGreen,
    output logic [4:0]            oBlue,
    output logic                  oHSync,
    output logic                  oVSync,
    output logic                  oBlank,
    output logic                  oFrameStart
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0]         hcnt_q;
    logic [VW-1:0]         vcnt_q;
    logic                  visible;
    logic                  blank_raw, hs_raw, vs_raw, origin_raw;
    logic                  blank_s1_q, hs_s1_q, vs_s1_q, origin_s1_q;
    logic                  en_d1_q;
    logic [DATA_WIDTH-1:0] data_hold_q;
    logic [DATA_WIDTH-1:0] pix_src;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (iPixelEnable) begin
            if (hcnt_q == H_LAST) begin
                hcnt_q <= '0;
                vcnt_q <= (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
            end else begin
                hcnt_q <= hcnt_q + HW'(1);
            end
        end
    end

    always_comb begin
        visible    = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        blank_raw  = ~visible;
        hs_raw     = ~((hcnt_q >= HS_START) && (hcnt_q < HS_END));
        vs_raw     = ~((vcnt_q >= VS_START) && (vcnt_q < VS_END));
        origin_raw = (hcnt_q == '0) && (vcnt_q == '0);
        oReadCol   = visible ? COL_BITS'(hcnt_q) : '0;
        oReadRow   = visible ? ROW_BITS'(vcnt_q) : '0;
        // Back-to-back ticks: the word for the stage-1 pixel is on iDataIn right now.
        // Gapped ticks: it arrived on the clock after stage 1 and was held.
        pix_src    = en_d1_q ? iDataIn : data_hold_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            blank_s1_q  <= 1'b1;
            hs_s1_q     <= 1'b1;
            vs_s1_q     <= 1'b1;
            origin_s1_q <= 1'b0;
            en_d1_q     <= 1'b0;
            data_hold_q <= '0;
            oBlank      <= 1'b1;
            oHSync      <= 1'b1;
            oVSync      <= 1'b1;
            oFrameStart <= 1'b0;
            oRed        <= '0;
            oGreen      <= '0;
            oBlue       <= '0;
        end else begin
            oFrameStart <= 1'b0;
            en_d1_q     <= iPixelEnable;
            if (en_d1_q) begin
                data_hold_q <= iDataIn;
            end
            if (iPixelEnable) begin
                blank_s1_q  <= blank_raw;
                hs_s1_q     <= hs_raw;
                vs_s1_q     <= vs_raw;
                origin_s1_q <= origin_raw;
                oBlank      <= blank_s1_q;
                oHSync      <= hs_s1_q;
                oVSync      <= vs_s1_q;
                oFrameStart <= origin_s1_q;
                if (blank_s1_q) begin
                    oRed   <= '0;
                    oGreen <= '0;
                    oBlue  <= '0;
                end else begin
                    oRed   <= pix_src[15:11];
                    oGreen <= pix_src[10:5];
                    oBlue  <= pix_src[4:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: default-timing instance plus a short-frame instance
// used for vertical timing and mid-frame reset.
module tb_vga_frame_reader;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Reset;
    logic        iPixelEnable;
    logic [15:0] ram_q;
    logic [15:0] data_b;
    int          mode;

    logic [8:0] row_a, row_b;
    logic [9:0] col_a, col_b;
    logic [4:0] r_a, r_b, b_a, b_b;
    logic [5:0] g_a, g_b;
    logic       hs_a, hs_b, vs_a, vs_b, bl_a, bl_b, fs_a, fs_b;

    vga_frame_reader dut_a (
        .Clock(Clock), .Reset(Reset), .iPixelEnable(iPixelEnable), .iDataIn(ram_q),
        .oReadRow(row_a), .oReadCol(col_a), .oRed(r_a), .oGreen(g_a), .oBlue(b_a),
        .oHSync(hs_a), .oVSync(vs_a), .oBlank(bl_a), .oFrameStart(fs_a)
    );

    // Ten-line frame keeps vertical checks short: vsync on lines 7..8, frame = 8000 clocks.
    vga_frame_reader #(
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_b (
        .Clock(Clock), .Reset(Reset), .iPixelEnable(iPixelEnable), .iDataIn(data_b),
        .oReadRow(row_b), .oReadCol(col_b), .oRed(r_b), .oGreen(g_b), .oBlue(b_b),
        .oHSync(hs_b), .oVSync(vs_b), .oBlank(bl_b), .oFrameStart(fs_b)
    );

    assign data_b = 16'hFFFF;

    function automatic logic [15:0] ram_word(input int md, input logic [8:0] r,
                                             input logic [9:0] c);
        if (md == 1) return 16'hFFFF;
        if (r == 9'd0 && c == 10'd0) return 16'hF800;
        if (r == 9'd0 && c == 10'd1) return 16'h07E0;
        return {r[4:0], 1'b0, c};
    endfunction

    always @(posedge Clock) ram_q <= ram_word(mode, row_a, col_a);

    int checks;
    int errors;
    int cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    typedef struct {
        int cyc; int md; int col; int row; int bl; int hs; int vs;
        int r; int g; int b; int fs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int c, input int md, input int col, input int row, input int bl,
                       input int hs, input int vs, input int r, input int g, input int b,
                       input int fs);
        vec_t v;
        v = '{c, md, col, row, bl, hs, vs, r, g, b, fs};
        vecs.push_back(v);
    endtask

    logic [37:0] snap;
    logic        was_en, prev_hs, prev_fs;
    int          ticks, viol, f1, f2, hlow, consec, vlow, vfall;
    int          fs_cyc[$];

    initial begin
        checks = 0; errors = 0; cyc = 0; mode = 0;
        //    cyc   md col  row bl hs vs  r   g   b  fs
        add(0,    0, 0,   0,  1, 1, 1, 0,  0,  0, 0);
        add(1,    0, 1,   0,  1, 1, 1, 0,  0,  0, 0);
        add(2,    0, 2,   0,  0, 1, 1, 31, 0,  0, 1);
        add(3,    0, 3,   0,  0, 1, 1, 0,  63, 0, 0);
        add(102,  0, 102, 0,  0, 1, 1, 0,  3,  4, 0);
        add(639,  0, 639, 0,  0, 1, 1, 0,  19, 29, 0);
        add(640,  0, 0,   0,  0, 1, 1, 0,  19, 30, 0);
        add(641,  0, 0,   0,  0, 1, 1, 0,  19, 31, 0);
        add(642,  0, 0,   0,  1, 1, 1, 0,  0,  0, 0);
        add(657,  0, 0,   0,  1, 1, 1, 0,  0,  0, 0);
        add(658,  0, 0,   0,  1, 0, 1, 0,  0,  0, 0);
        add(753,  0, 0,   0,  1, 0, 1, 0,  0,  0, 0);
        add(754,  0, 0,   0,  1, 1, 1, 0,  0,  0, 0);
        add(801,  0, 1,   1,  1, 1, 1, 0,  0,  0, 0);
        add(802,  0, 2,   1,  0, 1, 1, 1,  0,  0, 0);
        add(803,  0, 3,   1,  0, 1, 1, 1,  0,  1, 0);
        add(1457, 0, 0,   0,  1, 1, 1, 0,  0,  0, 0);
        add(1458, 0, 0,   0,  1, 0, 1, 0,  0,  0, 0);
        add(1602, 1, 2,   2,  0, 1, 1, 31, 63, 31, 0);
        add(2241, 1, 0,   0,  0, 1, 1, 31, 63, 31, 0);
        add(2242, 1, 0,   0,  1, 1, 1, 0,  0,  0, 0);
        add(2401, 1, 1,   3,  1, 1, 1, 0,  0,  0, 0);
        add(2402, 1, 2,   3,  0, 1, 1, 31, 63, 31, 0);

        // Reset with enable high: reset must win.
        Reset = 1'b1; iPixelEnable = 1'b1;
        repeat (3) step();
        check("rst_row", row_a, 0);
        check("rst_col", col_a, 0);
        check("rst_blank", bl_a, 1);
        check("rst_hsync", hs_a, 1);
        check("rst_vsync", vs_a, 1);
        check("rst_rgb", {r_a, g_a, b_a}, 0);
        check("rst_fs", fs_a, 0);
        check("rst_b_blank", bl_b, 1);

        Reset = 1'b0; cyc = 0;
        foreach (vecs[i]) begin
            mode = vecs[i].md;
            while (cyc < vecs[i].cyc) step();
            check($sformatf("v%0d.col", vecs[i].cyc), col_a, vecs[i].col);
            check($sformatf("v%0d.row", vecs[i].cyc), row_a, vecs[i].row);
            check($sformatf("v%0d.blank", vecs[i].cyc), bl_a, vecs[i].bl);
            check($sformatf("v%0d.hsync", vecs[i].cyc), hs_a, vecs[i].hs);
            check($sformatf("v%0d.vsync", vecs[i].cyc), vs_a, vecs[i].vs);
            check($sformatf("v%0d.red", vecs[i].cyc), r_a, vecs[i].r);
            check($sformatf("v%0d.green", vecs[i].cyc), g_a, vecs[i].g);
            check($sformatf("v%0d.blue", vecs[i].cyc), b_a, vecs[i].b);
            check($sformatf("v%0d.fs", vecs[i].cyc), fs_a, vecs[i].fs);
        end

        // Gapped enable: one tick every 4 clocks.
        mode = 0; Reset = 1'b1; step(); Reset = 1'b0;
        ticks = 0; viol = 0; f1 = -1; f2 = -1; hlow = 0; prev_hs = 1'b1;
        for (int k = 0; k < 7000; k++) begin
            iPixelEnable = (k % 4 == 0);
            was_en = iPixelEnable;
            snap = {col_a, row_a, r_a, g_a, b_a, hs_a, vs_a, bl_a};
            step();
            if (was_en) ticks++;
            else if (snap !== {col_a, row_a, r_a, g_a, b_a, hs_a, vs_a, bl_a}) viol++;
            if (was_en && ticks == 2) begin
                check("gap_t2_red", r_a, 31);
                check("gap_t2_fs", fs_a, 1);
            end
            if (!was_en && ticks == 2 && k % 4 == 1) check("gap_fs_width", fs_a, 0);
            if (was_en && ticks == 102) begin
                check("gap_t102_col", col_a, 102);
                check("gap_t102_gb", {g_a, b_a}, {6'd3, 5'd4});
                check("gap_t102_blank", bl_a, 0);
            end
            if (prev_hs && !hs_a) begin
                if (f1 < 0) f1 = k;
                else if (f2 < 0) f2 = k;
            end
            if (f1 >= 0 && f2 < 0 && !hs_a) hlow++;
            prev_hs = hs_a;
        end
        check("gap_hold_viol", viol, 0);
        check("gap_line_period", f2 - f1, 3200);
        check("gap_hsync_low", hlow, 384);

        // Frame timing on the short-frame instance.
        iPixelEnable = 1'b1; Reset = 1'b1; step(); Reset = 1'b0; cyc = 0;
        consec = 0; vlow = 0; vfall = -1; prev_fs = 1'b0; prev_hs = 1'b1;
        for (int k = 0; k < 16010; k++) begin
            step();
            if (fs_b) begin
                fs_cyc.push_back(cyc);
                if (prev_fs) consec++;
            end
            prev_fs = fs_b;
            if (!vs_b && cyc < 8000) vlow++;
            if (prev_hs && !vs_b && vfall < 0) vfall = cyc;
            prev_hs = vs_b;
        end
        check("frm_fs_count", fs_cyc.size(), 3);
        check("frm_fs_consec", consec, 0);
        check("frm_vsync_low", vlow, 1600);
        check("frm_vsync_fall", vfall, 5602);
        if (fs_cyc.size() == 3) begin
            check("frm_fs_first", fs_cyc[0], 2);
            check("frm_period_1", fs_cyc[1] - fs_cyc[0], 8000);
            check("frm_period_2", fs_cyc[2] - fs_cyc[1], 8000);
        end else begin
            check("frm_fs_list", fs_cyc.size(), 3);
        end

        // Reset pulsed mid-frame at line 3, pixel 300.
        Reset = 1'b1; step(); Reset = 1'b0; cyc = 0;
        while (cyc < 2700) step();
        check("mid_pre_row", row_b, 3);
        check("mid_pre_col", col_b, 300);
        check("mid_pre_blank", bl_b, 0);
        check("mid_pre_red", r_b, 31);
        Reset = 1'b1; step(); Reset = 1'b0;
        check("mid_rst_row", row_b, 0);
        check("mid_rst_col", col_b, 0);
        check("mid_rst_blank", bl_b, 1);
        check("mid_rst_sync", {hs_b, vs_b}, 2'b11);
        check("mid_rst_rgb", {r_b, g_b, b_b}, 0);
        check("mid_rst_fs", fs_b, 0);
        step();
        check("mid_t1_col", col_b, 1);
        check("mid_t1_fs", fs_b, 0);
        step();
        check("mid_t2_fs", fs_b, 1);
        step();
        check("mid_t3_fs", fs_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
